pong_input_ctrl: RTL and testbench

Front-end producer for the ping-pong game FSM: turns two raw, bouncy player push-buttons into clean, latched press flags (`P0`, `P1`) and generates the ball-advance tick `D`. The game FSM samples `P0`/`P1` and advances state only on cycles where `D` is high. This block guarantees that a press made anywhere in a tick window is presented, stable, during that window's `D` cycle. It sits between the board button pins and the game FSM, on the same clock.

---
 rtl/pong_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_pong_input_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_input_ctrl.sv
// ---------------------------------------------------------------------------
// pong_input_ctrl
//
// Front end for the ping-pong game FSM. Cleans up two bouncy player buttons
// into latched press flags and generates the ball-advance tick. A press made
// anywhere inside a tick window is presented, stable, during that window's
// D cycle, so the game FSM only has to sample P0/P1 when D is high.
//
// Parameters
//   DEB_CYCLES : consecutive stable cycles needed to accept a level change
//   TICK_SLOW  : D period for speed 2'b00
//   TICK_MED   : D period for speed 2'b01
//   TICK_FAST  : D period for speed 2'b10
//   CNT_W      : width of debounce and tick counters
//
// Ports
//   clk       in  : system clock
//   reset     in  : asynchronous, active-high reset
//   btn0_raw  in  : player 0 button, asynchronous, active-high
//   btn1_raw  in  : player 1 button, asynchronous, active-high
//   speed     in  : 00 slow, 01 medium, 10 fast, 11 paused
//   D         out : registered one-cycle tick for the game FSM
//   P0        out : registered latched press flag, player 0
//   P1        out : registered latched press flag, player 1
// ---------------------------------------------------------------------------
module pong_input_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int TICK_SLOW  = 25000000,
    parameter int TICK_MED   = 12500000,
    parameter int TICK_FAST  = 6250000,
    parameter int CNT_W      = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn0_raw,
    input  logic       btn1_raw,
    input  logic [1:0] speed,
    output logic       D,
    output logic       P0,
    output logic       P1
);

    localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOW_TERM = CNT_W'(TICK_SLOW - 1);
    localparam logic [CNT_W-1:0] MED_TERM  = CNT_W'(TICK_MED - 1);
    localparam logic [CNT_W-1:0] FAST_TERM = CNT_W'(TICK_FAST - 1);

    logic [1:0]       btn_raw_s;
    logic [1:0]       s1_r;
    logic [1:0]       s2_r;
    logic [1:0]       lvl_r;
    logic [CNT_W-1:0] dc_r [2];
    logic [1:0]       press_s;
    logic [CNT_W-1:0] tc_r;
    logic [CNT_W-1:0] term_s;

    assign btn_raw_s = {btn1_raw, btn0_raw};

    // Two-flop synchronizer for both buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r <= 2'b00;
            s2_r <= 2'b00;
        end else begin
            s1_r <= btn_raw_s;
            s2_r <= s1_r;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive
    // cycles of disagreement with the current stable level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_r    <= 2'b00;
            dc_r[0]  <= ZERO;
            dc_r[1]  <= ZERO;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (s2_r[b] == lvl_r[b]) begin
                    dc_r[b] <= ZERO;
                end else if (dc_r[b] == DEB_TERM) begin
                    lvl_r[b] <= s2_r[b];
                    dc_r[b]  <= ZERO;
                end else begin
                    dc_r[b] <= dc_r[b] + ONE;
                end
            end
        end
    end

    // A press is the edge on which the stable level is about to go 0 -> 1;
    // flagging it combinationally lets the flag land on the same edge as lvl.
    always_comb begin
        press_s = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if (s2_r[b] && !lvl_r[b] && (dc_r[b] == DEB_TERM)) begin
                press_s[b] = 1'b1;
            end else begin
                press_s[b] = 1'b0;
            end
        end
    end

    // Pending press flags: consumed by a D cycle, but a press arriving on
    // that very edge survives into the next window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            P0 <= 1'b0;
            P1 <= 1'b0;
        end else if (D) begin
            P0 <= press_s[0];
            P1 <= press_s[1];
        end else begin
            P0 <= P0 | press_s[0];
            P1 <= P1 | press_s[1];
        end
    end

    // Terminal count for the selected speed; paused maps to slow but the
    // tick process ignores it while paused.
    always_comb begin
        term_s = SLOW_TERM;
        case (speed)
            2'b00:   term_s = SLOW_TERM;
            2'b01:   term_s = MED_TERM;
            2'b10:   term_s = FAST_TERM;
            default: term_s = SLOW_TERM;
        endcase
    end

    // Tick generator. The >= compare makes a switch to a shorter period
    // fire at once if the counter is already past the new terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tc_r <= ZERO;
            D    <= 1'b0;
        end else if (speed == 2'b11) begin
            D    <= 1'b0;
        end else if (tc_r >= term_s) begin
            tc_r <= ZERO;
            D    <= 1'b1;
        end else begin
            tc_r <= tc_r + ONE;
            D    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pong_input_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pong_input_ctrl with small parameters. A behavioural model
// (sample-window debounce, elapsed-cycle tick, pending-press flags) runs
// alongside the DUT every cycle; directed table vectors and hand sequences
// add hard expectations for the documented corner cases.
// ---------------------------------------------------------------------------
module tb_pong_input_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn0_raw;
    logic       btn1_raw;
    logic [1:0] speed;
    logic       D;
    logic       P0;
    logic       P1;

    always #5 clk = ~clk;

    pong_input_ctrl #(
        .DEB_CYCLES(4),
        .TICK_SLOW (20),
        .TICK_MED  (10),
        .TICK_FAST (5),
        .CNT_W     (25)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn0_raw(btn0_raw),
        .btn1_raw(btn1_raw),
        .speed   (speed),
        .D       (D),
        .P0      (P0),
        .P1      (P1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    bit m_s1  [2];
    bit m_s2  [2];
    bit m_lvl [2];
    bit m_p   [2];
    bit hist  [2][DEB];
    bit m_d;
    int m_el;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0; m_p[b] = 1'b0;
            for (int j = 0; j < DEB; j++) hist[b][j] = 1'b0;
        end
        m_d  = 1'b0;
        m_el = 0;
    endfunction

    // One rising edge, using the input values present before the edge.
    function automatic void model_edge();
        bit raw [2];
        bit press [2];
        bit all_diff;
        bit d_old;
        int per;
        raw[0] = btn0_raw;
        raw[1] = btn1_raw;
        d_old  = m_d;
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < DEB - 1; j++) hist[b][j] = hist[b][j+1];
            hist[b][DEB-1] = m_s2[b];
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (hist[b][j] == m_lvl[b]) all_diff = 1'b0;
            press[b] = 1'b0;
            if (all_diff) begin
                m_lvl[b] = !m_lvl[b];
                press[b] = m_lvl[b];
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
            m_p[b]  = d_old ? press[b] : (m_p[b] | press[b]);
        end
        if (speed == 2'd3) begin
            m_d = 1'b0;
        end else begin
            per  = (speed == 2'd0) ? 20 : (speed == 2'd1) ? 10 : 5;
            m_el = m_el + 1;
            if (m_el >= per) begin
                m_d  = 1'b1;
                m_el = 0;
            end else begin
                m_d = 1'b0;
            end
        end
    endfunction

    task automatic check(input string name, input logic got, input logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic step(input logic b0, input logic b1, input logic [1:0] spd, input logic rst);
        btn0_raw = b0;
        btn1_raw = b1;
        speed    = spd;
        reset    = rst;
        if (rst) model_reset();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check("model_D",  D,  m_d);
        check("model_P0", P0, m_p[0]);
        check("model_P1", P1, m_p[1]);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       b0;
        logic       b1;
        logic [1:0] spd;
        logic       e_d;
        logic       e_p0;
        logic       e_p1;
    } vec_t;

    vec_t tbl [1:42];

    int  rises0, rises1;
    bit  prev0, prev1;
    bit  rb0, rb1, rr;
    logic [1:0] rs;
    bit  seen;

    initial begin
        // Vector i is applied before edge i after reset release; expected
        // outputs are sampled just after that edge.
        for (int i = 1; i <= 42; i++) begin
            tbl[i].b0   = ((i >= 2) && (i <= 4)) || ((i >= 10) && (i <= 19));
            tbl[i].b1   = (i >= 26);
            tbl[i].spd  = 2'b01;
            tbl[i].e_d  = ((i % 10) == 0);
            tbl[i].e_p0 = (i >= 15) && (i <= 20);
            tbl[i].e_p1 = (i >= 31) && (i <= 40);
        end

        reset = 1'b1; btn0_raw = 1'b0; btn1_raw = 1'b0; speed = 2'b01;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_D",  D,  1'b0);
        check("reset_P0", P0, 1'b0);
        check("reset_P1", P1, 1'b0);

        // Tick rate, 3-cycle glitch, held press, press on tick edge.
        for (int i = 1; i <= 42; i++) begin
            step(tbl[i].b0, tbl[i].b1, tbl[i].spd, 1'b0);
            check($sformatf("tbl%0d_D", i),  D,  tbl[i].e_d);
            check($sformatf("tbl%0d_P0", i), P0, tbl[i].e_p0);
            check($sformatf("tbl%0d_P1", i), P1, tbl[i].e_p1);
        end

        // Mid-window asynchronous reset with a press pending.
        for (int i = 43; i <= 48; i++) step(1'b1, 1'b0, 2'b01, 1'b0);
        check("pre_reset_P0", P0, 1'b1);
        btn0_raw = 1'b0;
        reset    = 1'b1;
        model_reset();
        #1;
        check("async_reset_D",  D,  1'b0);
        check("async_reset_P0", P0, 1'b0);
        check("async_reset_P1", P1, 1'b0);
        step(1'b0, 1'b0, 2'b01, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            step(1'b0, 1'b0, 2'b01, 1'b0);
            check($sformatf("post_reset_D%0d", j), D, (j == 10));
        end

        // Simultaneous bouncy presses from both players.
        rises0 = 0; rises1 = 0; prev0 = 1'b0; prev1 = 1'b0;
        for (int j = 0; j < 30; j++) begin
            if (j == 1)       step(1'b0, 1'b0, 2'b01, 1'b0);
            else if (j < 14)  step(1'b1, 1'b1, 2'b01, 1'b0);
            else              step(1'b0, 1'b0, 2'b01, 1'b0);
            check("sim_P0_eq_P1", P0, P1);
            if (P0 && !prev0) rises0++;
            if (P1 && !prev1) rises1++;
            prev0 = P0;
            prev1 = P1;
        end
        check("sim_P0_once", (rises0 == 1), 1'b1);
        check("sim_P1_once", (rises1 == 1), 1'b1);

        // Speed change from slow with tc=12 to fast fires immediately.
        step(1'b0, 1'b0, 2'b00, 1'b1);
        for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 2'b00, 1'b0);
        check("slow_no_tick", D, 1'b0);
        step(1'b0, 1'b0, 2'b10, 1'b0);
        check("speed_switch_D", D, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            step(1'b0, 1'b0, 2'b10, 1'b0);
            check($sformatf("fast_D%0d", j), D, ((j % 5) == 0));
        end

        // Pause with a press pending.
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            step(1'b1, 1'b0, 2'b10, 1'b0);
            if (m_p[0] && !m_d) seen = 1'b1;
        end
        check("pause_setup", seen, 1'b1);
        for (int j = 0; j < 20; j++) begin
            step((j < 10), 1'b0, 2'b11, 1'b0);
            check("pause_D",  D,  1'b0);
            check("pause_P0", P0, 1'b1);
        end
        seen = 1'b0;
        for (int j = 0; j < 10 && !seen; j++) begin
            step(1'b0, 1'b0, 2'b10, 1'b0);
            if (D) seen = 1'b1;
        end
        check("resume_tick", seen, 1'b1);
        check("resume_P0_during_D", P0, 1'b1);
        step(1'b0, 1'b0, 2'b10, 1'b0);
        check("resume_P0_cleared", P0, 1'b0);

        // Randomized stimulus against the model.
        rb0 = 1'b0; rb1 = 1'b0; rs = 2'b01;
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 7) == 0)   rb0 = !rb0;
            if ($urandom_range(0, 7) == 0)   rb1 = !rb1;
            if ($urandom_range(0, 63) == 0)  rs  = 2'($urandom_range(0, 3));
            rr = ($urandom_range(0, 599) == 0);
            step(rb0, rb1, rs, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
